stage_enable_sequencer: RTL and testbench

//  Clocked, parametrised successor of the core's stage-enable controller.

---
 rtl/stage_enable_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_stage_enable_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_enable_sequencer.sv
// Single-clock stage-enable sequencer: walks one enable per pipeline stage in index order
// with per-stage hold counts and a per-instruction skip mask. Optional HOLD/step mode: STAGE_SEQ_STEP_MODE_EN.
module stage_enable_sequencer #(
    parameter int unsigned NUM_STAGES = 12,
    parameter int unsigned DLY_W      = 4,
    parameter int unsigned BOOT_STAGE = 9,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  logic                        boot_i,
    input  logic                        stop_i,
    input  logic                        step_i,
    input  logic [NUM_STAGES-1:0]       skip_mask_i,
    input  logic [NUM_STAGES*DLY_W-1:0] dly_cfg_i,
    output logic [NUM_STAGES-1:0]       en_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [CNT_W-1:0]            instr_cnt_o
);

    localparam int unsigned IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

`ifdef STAGE_SEQ_STEP_MODE_EN
    typedef enum logic [1:0] {IDLE, BOOT, RUN, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, BOOT, RUN} state_t;
`endif

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DLY_W-1:0]        hold_q, hold_d;
    logic                    stop_q, stop_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_STAGES-1:0]   en_q, en_d;
    logic                    busy_q, busy_d;
    logic                    done_c;

    logic [DLY_W-1:0]        dly_arr [NUM_STAGES];
    logic                    nxt_found;
    logic [IDX_W-1:0]        nxt_idx;
    logic                    unused_inputs;

    // Stage 0 always runs, so mask bit 0 never participates.
`ifdef STAGE_SEQ_STEP_MODE_EN
    assign unused_inputs = skip_mask_i[0];
`else
    assign unused_inputs = skip_mask_i[0] ^ step_i;
`endif

    // Per-stage hold-count fields.
    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            dly_arr[k] = dly_cfg_i[k*DLY_W +: DLY_W];
        end
    end

    // Lowest unskipped stage above the current one.
    always_comb begin
        nxt_found = 1'b0;
        nxt_idx   = '0;
        for (int j = NUM_STAGES - 1; j > 0; j--) begin
            if ((IDX_W'(j) > idx_q) && !skip_mask_i[j]) begin
                nxt_found = 1'b1;
                nxt_idx   = IDX_W'(j);
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        stop_d  = stop_q;
        cnt_d   = cnt_q;
        done_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    stop_d  = 1'b0;
                    idx_d   = '0;
                    hold_d  = dly_arr[0];
                    state_d = boot_i ? BOOT : RUN;
                end
            end
            BOOT: begin
                if (stop_i) begin
                    stop_d = 1'b1;
                end
                state_d = RUN;
                idx_d   = '0;
                hold_d  = dly_arr[0];
            end
            RUN: begin
                if (stop_i) begin
                    stop_d = 1'b1;
                end
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else if (nxt_found) begin
                    idx_d  = nxt_idx;
                    hold_d = dly_arr[nxt_idx];
                end else begin
                    // Last cycle of the instruction.
                    done_c = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (stop_q || stop_i) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        hold_d  = '0;
                    end else begin
`ifdef STAGE_SEQ_STEP_MODE_EN
                        state_d = HOLD;
                        idx_d   = '0;
                        hold_d  = '0;
`else
                        idx_d   = '0;
                        hold_d  = dly_arr[0];
`endif
                    end
                end
            end
`ifdef STAGE_SEQ_STEP_MODE_EN
            HOLD: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (step_i) begin
                    state_d = RUN;
                    idx_d   = '0;
                    hold_d  = dly_arr[0];
                end
            end
`endif
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                hold_d  = '0;
            end
        endcase

        en_d = '0;
        if (state_d == BOOT) begin
            en_d = NUM_STAGES'(1) << BOOT_STAGE;
        end else if (state_d == RUN) begin
            en_d = NUM_STAGES'(1) << idx_d;
        end
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            stop_q  <= 1'b0;
            cnt_q   <= '0;
            en_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            stop_q  <= stop_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
        end
    end

    // done_o depends on the skip mask sampled in the completing cycle itself.
    assign en_o        = en_q;
    assign busy_o      = busy_q;
    assign done_o      = done_c;
    assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_stage_enable_sequencer.sv
// Self-checking bench for stage_enable_sequencer: directed scenarios with literal expectations
// plus a randomized run compared every cycle against a stage/remaining-cycles reference model.
module tb_stage_enable_sequencer;

    localparam int unsigned NS = 12;
    localparam int unsigned DW = 4;
    localparam int unsigned BS = 9;
    localparam int unsigned CW = 6;
`ifdef STAGE_SEQ_STEP_MODE_EN
    localparam bit STEP = 1'b1;
`else
    localparam bit STEP = 1'b0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_BOOT = 1;
    localparam int M_RUN  = 2;
    localparam int M_HOLD = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           boot = 1'b0;
    logic           stop = 1'b0;
    logic           step = 1'b0;
    logic [NS-1:0]  mask = '0;
    logic [NS*DW-1:0] dly = '0;
    logic [NS-1:0]  en;
    logic           busy;
    logic           done;
    logic [CW-1:0]  cnt;

    int n_chk = 0;
    int n_fail = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    stage_enable_sequencer #(
        .NUM_STAGES(NS), .DLY_W(DW), .BOOT_STAGE(BS), .CNT_W(CW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .boot_i(boot), .stop_i(stop),
        .step_i(step), .skip_mask_i(mask), .dly_cfg_i(dly), .en_o(en), .busy_o(busy),
        .done_o(done), .instr_cnt_o(cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: current mode, stage and cycles left in that stage.
    int            m_mode, m_stage, m_left;
    bit            m_latch;
    logic [CW-1:0] m_cnt;

    function automatic int next_stage(input int s, input logic [NS-1:0] mk);
        for (int j = s + 1; j < NS; j++) begin
            if (!mk[j]) return j;
        end
        return -1;
    endfunction

    function automatic int dly_of(input int s, input logic [NS*DW-1:0] d);
        return int'(d[s*DW +: DW]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  <= M_IDLE;
            m_stage <= 0;
            m_left  <= 0;
            m_latch <= 1'b0;
            m_cnt   <= '0;
        end else begin : model_step
            int mode, stg, left, nx;
            bit latch;
            logic [CW-1:0] c;
            mode = m_mode; stg = m_stage; left = m_left; latch = m_latch; c = m_cnt;
            case (mode)
                M_IDLE: if (start) begin
                    latch = 1'b0; stg = 0; left = dly_of(0, dly) + 1;
                    mode = boot ? M_BOOT : M_RUN;
                end
                M_BOOT: begin
                    latch = latch | stop; mode = M_RUN; stg = 0; left = dly_of(0, dly) + 1;
                end
                M_RUN: begin
                    latch = latch | stop;
                    if (left > 1) begin
                        left = left - 1;
                    end else begin
                        nx = next_stage(stg, mask);
                        if (nx >= 0) begin
                            stg = nx; left = dly_of(nx, dly) + 1;
                        end else begin
                            c = c + 1'b1;
                            if (latch) mode = M_IDLE;
                            else if (STEP) mode = M_HOLD;
                            else begin stg = 0; left = dly_of(0, dly) + 1; end
                        end
                    end
                end
                default: begin
                    if (stop) mode = M_IDLE;
                    else if (step) begin mode = M_RUN; stg = 0; left = dly_of(0, dly) + 1; end
                end
            endcase
            m_mode <= mode; m_stage <= stg; m_left <= left; m_latch <= latch; m_cnt <= c;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin : cmp
            logic [NS-1:0] e;
            e = '0;
            if (m_mode == M_BOOT) e[BS] = 1'b1;
            else if (m_mode == M_RUN) e[m_stage] = 1'b1;
            chk("model_en", 32'(en), 32'(e));
            chk("model_busy", 32'(busy), 32'(m_mode != M_IDLE));
            chk("model_done", 32'(done),
                32'((m_mode == M_RUN) && (m_left == 1) && (next_stage(m_stage, mask) < 0)));
            chk("model_cnt", 32'(cnt), 32'(m_cnt));
        end
    end

    task automatic step_cyc(); @(posedge clk); #1; endtask
    task automatic look();     @(negedge clk); #1; endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; boot = 1'b0; stop = 1'b0; step = 1'b0;
        look();
        rst_n = 1'b1;
        step_cyc();
    endtask

    // Start one instruction and check en/done literally against exp_q; stop pulsed in cycle stop_at.
    task automatic run_seq(input bit b, input int stop_at);
        start = 1'b1; boot = b; stop = 1'b0;
        step_cyc();
        start = 1'b0; boot = 1'b0; stop = (stop_at == 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            look();
            chk("seq_en", 32'(en), 32'(exp_q[i]));
            chk("seq_done", 32'(done), 32'(i == exp_q.size() - 1));
            step_cyc();
            stop = (i + 1 == stop_at);
        end
        stop = 1'b0;
    endtask

    task automatic post_idle(input int exp_cnt);
        look();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_en", 32'(en), 32'd0);
        chk("idle_cnt", 32'(cnt), 32'(exp_cnt));
        step_cyc();
    endtask

    task automatic drain();
        int k;
        stop = 1'b1;
        step_cyc();
        stop = 1'b0;
        k = 0;
        while (busy && k < 400) begin
            step_cyc();
            k++;
        end
        chk("drain_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        do_reset();
        look();
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        step_cyc();

        // T1: plain walk of all stages.
        exp_q = {};
        for (int k = 0; k < NS; k++) exp_q.push_back(1 << k);
        run_seq(1'b0, -1);
        look();
        if (STEP) begin
            chk("t1_hold_en", 32'(en), 32'd0);
            chk("t1_hold_busy", 32'(busy), 32'd1);
        end else begin
            chk("t1_reenter_en", 32'(en), 32'd1);
        end
        chk("t1_cnt", 32'(cnt), 32'd1);
        drain();
        chk("t1_cnt_after_stop", 32'(cnt), STEP ? 32'd1 : 32'd2);

        // T2: stage 6 held four cycles.
        do_reset();
        dly[6*DW +: DW] = DW'(3);
        exp_q = {};
        for (int k = 0; k < NS; k++) begin
            exp_q.push_back(1 << k);
            if (k == 6) repeat (3) exp_q.push_back(1 << 6);
        end
        run_seq(1'b0, 1);
        post_idle(1);

        // T3: skip stages 4..6, then skip everything.
        dly = '0;
        mask = NS'(12'h070);
        exp_q = {1, 2, 4, 8, 1 << 7, 1 << 8, 1 << 9, 1 << 10, 1 << 11};
        run_seq(1'b0, 1);
        post_idle(2);
        mask = NS'(12'hFFF);
        exp_q = {1};
        run_seq(1'b0, 0);
        post_idle(3);

        // T4: boot stage then stop pulsed during stage 2.
        do_reset();
        mask = '0;
        exp_q = {1 << BS};
        for (int k = 0; k < NS; k++) exp_q.push_back(1 << k);
        run_seq(1'b1, 3);
        post_idle(1);

        // T5: asynchronous reset in the middle of stage 5.
        start = 1'b1;
        step_cyc();
        start = 1'b0;
        repeat (5) step_cyc();
        chk("t5_stage5", 32'(en), 32'(1 << 5));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_en", 32'(en), 32'd0);
        chk("t5_async_busy", 32'(busy), 32'd0);
        chk("t5_async_done", 32'(done), 32'd0);
        chk("t5_async_cnt", 32'(cnt), 32'd0);
        look();
        rst_n = 1'b1;
        step_cyc();
        mask = NS'(12'hFFE);
        exp_q = {1};
        run_seq(1'b0, 0);
        post_idle(1);
        mask = '0;

        if (STEP) begin : t6
            int k;
            do_reset();
            exp_q = {};
            for (int s = 0; s < NS; s++) exp_q.push_back(1 << s);
            run_seq(1'b0, -1);
            for (int s = 0; s < 10; s++) begin
                look();
                chk("t6_hold_en", 32'(en), 32'd0);
                chk("t6_hold_busy", 32'(busy), 32'd1);
            end
            step = 1'b1;
            step_cyc();
            step = 1'b0;
            look();
            chk("t6_step_en", 32'(en), 32'd1);
            k = 0;
            while (!done && k < 50) begin look(); k++; end
            chk("t6_done_seen", 32'(done), 32'd1);
            step_cyc();
            stop = 1'b1;
            step_cyc();
            stop = 1'b0;
            chk("t6_stop_busy", 32'(busy), 32'd0);
            chk("t6_cnt", 32'(cnt), 32'd2);
        end

        // Randomized run against the model; the 6-bit counter wraps many times.
        do_reset();
        for (int c = 0; c < 6000; c++) begin
            start = ($urandom_range(0, 7) == 0);
            boot  = ($urandom_range(0, 2) == 0);
            stop  = ($urandom_range(0, 63) == 0);
            step  = ($urandom_range(0, 5) == 0);
            mask  = ($urandom_range(0, 7) == 0) ? '0 : NS'($urandom & $urandom);
            for (int k = 0; k < NS; k++) dly[k*DW +: DW] = DW'($urandom_range(0, 3));
            step_cyc();
        end
        start = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
